// File: rtl/idelay_cal_pkg.sv
// Shared types and constants for the IODELAYE1 tap calibrator.
package idelay_cal_pkg;

  localparam int TAP_W    = 5;   // IODELAYE1 CNTVALUE width
  localparam int NUM_TAPS = 32;  // taps swept per lane
  localparam int RUN_W    = 6;   // window lengths reach 32, so one bit wider than a tap
  localparam int CNT_W    = 10;  // covers SAMPLE_CYCLES up to 1023

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_APPLY,
    ST_DONE
  } cal_state_t;

endpackage

// File: rtl/idelay_cal_window.sv
// Per-lane pass-window tracker: sticky error flag for the current tap, plus the
// current and best runs of consecutive passing taps. The centre and fail
// outputs are derived from the next-state values so the top level can register
// them in the same cycle the last tap is scored.
module idelay_cal_window
  import idelay_cal_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             err_clr,
  input  logic             sample_en,
  input  logic             mismatch,
  input  logic             eval_en,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] center_next,
  output logic             fail_next
);

  logic             err_q, err_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] best_len_q, best_len_d;
  logic [TAP_W-1:0] run_start_q, run_start_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;

  // Next-state of the error flag and window tracker.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    err_d        = err_q;
    run_len_d    = run_len_q;
    best_len_d   = best_len_q;
    run_start_d  = run_start_q;
    best_start_d = best_start_q;
    if (clear) begin
      err_d        = 1'b0;
      run_len_d    = '0;
      best_len_d   = '0;
      run_start_d  = '0;
      best_start_d = '0;
    end else begin
      if (err_clr)
        err_d = 1'b0;
      else if (sample_en && mismatch)
        err_d = 1'b1;

      if (eval_en) begin
        if (!err_q) begin
          if (run_len_q == '0)
            run_start_d = tap;
          run_len_d = run_len_q + RUN_W'(1);
          // Strict compare: an equal-length later window never displaces an earlier one.
          if (run_len_d > best_len_q) begin
            best_len_d   = run_len_d;
            best_start_d = run_start_d;
          end
        end else begin
          run_len_d = '0;
        end
      end
    end
  end

  // Tracker registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      err_q        <= 1'b0;
      run_len_q    <= '0;
      best_len_q   <= '0;
      run_start_q  <= '0;
      best_start_q <= '0;
    end else begin
      err_q        <= err_d;
      run_len_q    <= run_len_d;
      best_len_q   <= best_len_d;
      run_start_q  <= run_start_d;
      best_start_q <= best_start_d;
    end
  end

  // best_start + best_len <= 32, so start + len/2 always fits in a tap.
  assign center_next = best_start_d + best_len_d[RUN_W-1:1];
  assign fail_next   = (best_len_d == '0);

endmodule

// File: rtl/idelay_tap_calibrator.sv
// Sweeps all IODELAYE1 taps on every lane in parallel against a known ADC test
// pattern, then loads each lane with the centre of its widest passing window.
module idelay_tap_calibrator
  import idelay_cal_pkg::*;
#(
  parameter int NUM_LANES     = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic                       adc_dco_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_LANES-1:0]       data_p,
  input  logic [NUM_LANES-1:0]       data_n,
  input  logic [NUM_LANES-1:0]       expected_p,
  input  logic [NUM_LANES-1:0]       expected_n,
  output logic [NUM_LANES-1:0]       delay_ld,
  output logic [TAP_W-1:0]           delay_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_LANES-1:0]       lane_fail,
  output logic [TAP_W*NUM_LANES-1:0] tap_center
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  cal_state_t        state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic                       start_acc;
  logic [NUM_LANES-1:0]       mismatch;
  logic [TAP_W-1:0]           center_next [NUM_LANES];
  logic [NUM_LANES-1:0]       fail_next;
  logic [TAP_W*NUM_LANES-1:0] center_flat;

  logic [NUM_LANES-1:0] ld_d;
  logic [TAP_W-1:0]     wdata_d;
  logic                 busy_d, done_d;

  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mismatch[i] = (data_p[i] != expected_p[i]) || (data_n[i] != expected_n[i]);

    idelay_cal_window u_window (
      .clk         (adc_dco_clk),
      .reset       (reset),
      .clear       (start_acc),
      .err_clr     (state_q == ST_LOAD),
      .sample_en   (state_q == ST_SAMPLE),
      .mismatch    (mismatch[i]),
      .eval_en     (state_q == ST_EVAL),
      .tap         (tap_q),
      .center_next (center_next[i]),
      .fail_next   (fail_next[i])
    );

    assign center_flat[TAP_W*i +: TAP_W] = center_next[i];
  end

  // State, tap, dwell counter and lane index registers.
  always_ff @(posedge adc_dco_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_LOAD;
        tap_d   = '0;
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
      ST_SAMPLE: if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) state_d = ST_EVAL;
      ST_EVAL: begin
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = ST_APPLY;
          lane_d  = '0;
        end else begin
          state_d = ST_LOAD;
          tap_d   = tap_q + TAP_W'(1);
        end
      end
      ST_APPLY: begin
        lane_d = lane_q + LANE_W'(1);
        if (lane_q == LANE_W'(NUM_LANES - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == state_q && (state_q == ST_SETTLE || state_q == ST_SAMPLE))
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = '0;
  end

  // Output decode from the next state so the registered strobes line up with it.
  always_comb begin
    ld_d    = '0;
    wdata_d = '0;
    busy_d  = !(state_d == ST_IDLE || state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_LOAD: begin
        ld_d    = '1;
        wdata_d = tap_d;
      end
      ST_APPLY: begin
        ld_d[lane_d] = 1'b1;
        wdata_d      = center_next[lane_d];
      end
      default: ;
    endcase
  end

  // Registered outputs; results are captured as the last lane is applied.
  always_ff @(posedge adc_dco_clk) begin
    if (reset) begin
      delay_ld    <= '0;
      delay_wdata <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lane_fail   <= '0;
      tap_center  <= '0;
    end else begin
      delay_ld    <= ld_d;
      delay_wdata <= wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      if (state_q == ST_APPLY && state_d == ST_DONE) begin
        lane_fail  <= fail_next;
        tap_center <= center_flat;
      end
    end
  end

endmodule

// File: doc/idelay_tap_calibrator.md
# idelay_tap_calibrator

Per-lane IODELAYE1 tap calibration controller for the 8-lane AD9284 LVDS capture path. It sits in the `adc_dco_clk` domain beside the IODELAYE1/IDDR input stage, which is configured for variable-loadable delay. While the ADC emits a known test pattern, the block sweeps all 32 taps on every lane in parallel and scores each tap against the expected IDDR outputs. It then loads each lane's delay with the centre of its widest passing window.

## Interface
- `NUM_LANES`, 8, number of ADC data lanes.
- `SETTLE_CYCLES`, 16, cycles waited after a tap load before scoring starts (1..255).
- `SAMPLE_CYCLES`, 64, cycles scored per tap (1..1023).

- `adc_dco_clk`  in  1  capture clock (BUFR output); the only clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to calibrate; ignored unless idle.
- `data_p`  in  NUM_LANES  IDDR Q1 per lane.
- `data_n`  in  NUM_LANES  IDDR Q2 per lane.
- `expected_p`  in  NUM_LANES  expected Q1 per lane; held static during calibration.
- `expected_n`  in  NUM_LANES  expected Q2 per lane; held static during calibration.
- `delay_ld`  out  NUM_LANES  per-lane IODELAYE1 load strobe; the IODELAY captures `delay_wdata` on the same clock edge.
- `delay_wdata`  out  5  shared CNTVALUEIN.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` rises.
- `done`  out  1  level; high after completion until the next accepted `start` or `reset`.
- `lane_fail`  out  NUM_LANES  lane had no passing tap; valid while `done` is high.
- `tap_center`  out  5*NUM_LANES  chosen tap per lane; lane i occupies bits [5i+4:5i]; valid while `done` is high.

## Operation
- Reset values: `delay_ld`=0, `delay_wdata`=0, `busy`=0, `done`=0, `lane_fail`=0, `tap_center`=0, state IDLE, all trackers cleared.
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE.
  - IDLE/DONE, `start`=1: tap:=0, trackers cleared, `done`:=0; go to LOAD.
  - LOAD, 1 cycle: `delay_ld`=all ones, `delay_wdata`=tap, per-lane error flags cleared; go to SETTLE.
  - SETTLE: lasts SETTLE_CYCLES cycles; go to SAMPLE.
  - SAMPLE: lasts SAMPLE_CYCLES cycles. Each cycle, a lane's sticky error flag is set if `data_p`≠`expected_p` or `data_n`≠`expected_n` for that lane; go to EVAL.
  - EVAL, 1 cycle: each lane's window tracker is updated with pass = !err. If tap=31, go to APPLY with lane:=0; else tap++ and go to LOAD.
  - APPLY: one cycle per lane, in ascending lane order. Drives `delay_wdata`=centre[lane] and `delay_ld`=one-hot(lane). After the last lane, go to DONE.
  - DONE: `busy`=0, `done`=1; hold until `start`.
- Window tracker, per lane; `run_len`/`best_len` are 6 bits, `run_start`/`best_start` are 5 bits:
  - On pass: if `run_len`=0, set `run_start`:=tap. Then `run_len`++. If the new `run_len` > `best_len`, set best:=run.
  - On fail: `run_len`:=0.
  - Strict `>` means ties keep the lowest-tap window.
  - Taps do not wrap; 31 and 0 are not adjacent.
- centre = `best_start` + (`best_len`>>1). This always fits in 5 bits.
- If `best_len`=0: `lane_fail`=1 and centre=0. Tap 0 is still loaded in APPLY.
- `start` while busy: ignored.
- `reset` mid-operation: next cycle the block is in IDLE with all outputs at reset values. IODELAYs keep their last loaded tap.

## Timing
- Per tap: 2 + SETTLE_CYCLES + SAMPLE_CYCLES cycles.
- `start` sampled at edge 0 → LOAD at cycle 1.
- `done` rises at cycle 1 + 32·(2+SETTLE+SAMPLE) + NUM_LANES. With defaults this is cycle 2633.
- Outputs are registered. `delay_ld` is never asserted outside LOAD and APPLY.

## Structure
- Package `idelay_cal_pkg` holds:
  - the state enum;
  - `TAP_W`=5;
  - `NUM_TAPS`=32;
  - `RUN_W`=6.
- Sub-module `idelay_cal_window` is the per-lane tracker (err flag, run/best registers, centre and fail outputs). It is instantiated NUM_LANES times; the top level holds the FSM, counters and APPLY mux.

## Test plan
Bench models IODELAY: each lane's `data_*` equals `expected_*` iff the last loaded tap is in that lane's pass set.
- All lanes pass every tap → `tap_center`=16 on all lanes, `lane_fail`=0, `done` at cycle 2633.
- Lane 3 passes only taps 10..19 → lane 3 centre 15; other lanes 16.
- Lane 5 passes taps 2..6 and 20..24 (tie) → centre 4.
- Lane 0 never passes → `lane_fail`=0x01, centre 0; APPLY still pulses `delay_ld[0]` with `delay_wdata`=0.
- Lane 7 passes everywhere except one mismatch on the final SAMPLE cycle of tap 12 → best window 13..31 (length 19), centre 22.
- `reset` during SAMPLE of tap 7 → next cycle `busy`/`done`/`delay_ld` are 0. A second `start` pulsed while busy is ignored. A fresh run then produces case-1 results.
